// File: rtl/estacao_reserva_pkg.sv
// ---------------------------------------------------------------------------
// estacao_reserva_pkg
// Shared constants and types for the ADD-class reservation stations of the
// Tomasulo datapath.
//   - Tags used on the CDB and in the Qj/Qk/Qi fields (0 means "value present")
//   - Opcodes understood by the ADD-class ALU
//   - Reset values for held operands and tags
//   - State encoding of the station controller
// ---------------------------------------------------------------------------
package estacao_reserva_pkg;

    // Tags of the producers that can appear on the CDB
    localparam logic [2:0] FREE_REGISTER    = 3'd0;
    localparam logic [2:0] RES_STATION_ADD1 = 3'd1;
    localparam logic [2:0] RES_STATION_ADD2 = 3'd2;

    // Opcodes of the ADD-class functional unit
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;

    // Values held by an empty station
    localparam logic [15:0] Vj_Vk_sem_valor = 16'hFFF0;
    localparam logic [2:0]  Qj_Qk_sem_valor = 3'd0;

    // Station controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        EXEC     = 2'd2,
        WB       = 2'd3
    } rsState_t;

endpackage

// File: rtl/estacao_reserva_add_ula.sv
// ---------------------------------------------------------------------------
// ula_add
// Combinational 16-bit ALU of the ADD-class functional unit. Wrap-around
// arithmetic, no flags. Unknown opcodes produce zero.
// Ports:
//   Ufop   in  3   opcode
//   A      in  16  operand j
//   B      in  16  operand k
//   Result out 16  operation result
// ---------------------------------------------------------------------------
module ula_add
    import estacao_reserva_pkg::*;
(
    input  logic [2:0]  Ufop,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Result
);

    // Select the operation; anything outside the ADD class yields zero
    always_comb begin
        Result = 16'h0000;
        case (Ufop)
            OP_ADD:  Result = A + B;
            OP_SUB:  Result = A - B;
            OP_AND:  Result = A & B;
            OP_OR:   Result = A | B;
            default: Result = 16'h0000;
        endcase
    end

endmodule

// File: rtl/estacao_reserva_add.sv
// ---------------------------------------------------------------------------
// estacao_reserva_add
// One ADD-class reservation station. Takes an instruction from dispatch,
// snoops the CDB for missing operands, executes for EXEC_LATENCY cycles and
// then requests the CDB to broadcast its result under its own tag.
// Ports:
//   Clock, Reset_n             clock (rising edge), async active-low reset
//   Enable_VQ, Ufop, Vj, Vk,   dispatch strobe and instruction fields
//   Qj, Qk, R_target
//   Cdb_valid/tag/data         CDB snoop inputs
//   Cdb_grant                  CDB arbiter grant
//   Busy                       station occupied (back to dispatch)
//   Cdb_req, Cdb_tag_out,      result broadcast request, tag, value and
//   Cdb_data_out, R_target_out destination register
//   Dispatch_drop              pulse: a dispatch arrived while Busy
// ---------------------------------------------------------------------------
module estacao_reserva_add
    import estacao_reserva_pkg::*;
#(
    parameter logic [2:0]  RS_TAG       = RES_STATION_ADD1,
    parameter int unsigned EXEC_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Enable_VQ,
    input  logic [2:0]  Ufop,
    input  logic [15:0] Vj,
    input  logic [15:0] Vk,
    input  logic [2:0]  Qj,
    input  logic [2:0]  Qk,
    input  logic [3:0]  R_target,
    input  logic        Cdb_valid,
    input  logic [2:0]  Cdb_tag,
    input  logic [15:0] Cdb_data,
    input  logic        Cdb_grant,
    output logic        Busy,
    output logic        Cdb_req,
    output logic [2:0]  Cdb_tag_out,
    output logic [15:0] Cdb_data_out,
    output logic [3:0]  R_target_out,
    output logic        Dispatch_drop
);

    rsState_t    state_q;
    logic [2:0]  ufop_q;
    logic [15:0] vj_q;
    logic [15:0] vk_q;
    logic [2:0]  qj_q;
    logic [2:0]  qk_q;
    logic [3:0]  rTarget_q;
    logic [3:0]  counter_q;
    logic [15:0] result_q;
    logic        busy_q;
    logic        cdbReq_q;
    logic [2:0]  tagOut_q;
    logic        drop_q;

    logic [15:0] captureVj_d;
    logic [15:0] captureVk_d;
    logic [2:0]  captureQj_d;
    logic [2:0]  captureQk_d;
    logic [15:0] aluResult;

    // Same-cycle forwarding at capture: an operand being broadcast on the
    // very edge it is dispatched is taken from the CDB instead of waiting
    // for a broadcast that has already gone by.
    always_comb begin
        captureVj_d = Vj;
        captureQj_d = Qj;
        captureVk_d = Vk;
        captureQk_d = Qk;
        if (Cdb_valid && (Qj != FREE_REGISTER) && (Cdb_tag == Qj)) begin
            captureVj_d = Cdb_data;
            captureQj_d = Qj_Qk_sem_valor;
        end
        if (Cdb_valid && (Qk != FREE_REGISTER) && (Cdb_tag == Qk)) begin
            captureVk_d = Cdb_data;
            captureQk_d = Qj_Qk_sem_valor;
        end
    end

    ula_add u_ula (
        .Ufop   (ufop_q),
        .A      (vj_q),
        .B      (vk_q),
        .Result (aluResult)
    );

    // Station controller. Cdb_req is raised one cycle after entering WB so
    // that a grant is only honoured once the request is actually visible
    // to the arbiter; the held result and destination stay put until then.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            ufop_q    <= OP_NOP;
            vj_q      <= Vj_Vk_sem_valor;
            vk_q      <= Vj_Vk_sem_valor;
            qj_q      <= Qj_Qk_sem_valor;
            qk_q      <= Qj_Qk_sem_valor;
            rTarget_q <= 4'd0;
            counter_q <= 4'd0;
            result_q  <= Vj_Vk_sem_valor;
            busy_q    <= 1'b0;
            cdbReq_q  <= 1'b0;
            tagOut_q  <= FREE_REGISTER;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= Enable_VQ && busy_q;
            case (state_q)
                IDLE: begin
                    if (Enable_VQ && (Ufop != OP_NOP)) begin
                        ufop_q    <= Ufop;
                        rTarget_q <= R_target;
                        vj_q      <= captureVj_d;
                        vk_q      <= captureVk_d;
                        qj_q      <= captureQj_d;
                        qk_q      <= captureQk_d;
                        busy_q    <= 1'b1;
                        state_q   <= WAIT_OPS;
                    end
                end
                WAIT_OPS: begin
                    if (Cdb_valid && (qj_q != FREE_REGISTER) && (Cdb_tag == qj_q)) begin
                        vj_q <= Cdb_data;
                        qj_q <= Qj_Qk_sem_valor;
                    end
                    if (Cdb_valid && (qk_q != FREE_REGISTER) && (Cdb_tag == qk_q)) begin
                        vk_q <= Cdb_data;
                        qk_q <= Qj_Qk_sem_valor;
                    end
                    if ((qj_q == FREE_REGISTER) && (qk_q == FREE_REGISTER)) begin
                        counter_q <= 4'(EXEC_LATENCY - 1);
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (counter_q == 4'd0) begin
                        result_q <= aluResult;
                        state_q  <= WB;
                    end else begin
                        counter_q <= counter_q - 4'd1;
                    end
                end
                WB: begin
                    if (cdbReq_q && Cdb_grant) begin
                        cdbReq_q <= 1'b0;
                        tagOut_q <= FREE_REGISTER;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        cdbReq_q <= 1'b1;
                        tagOut_q <= RS_TAG;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy          = busy_q;
    assign Cdb_req       = cdbReq_q;
    assign Cdb_tag_out   = tagOut_q;
    assign Cdb_data_out  = result_q;
    assign R_target_out  = rTarget_q;
    assign Dispatch_drop = drop_q;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// ---------------------------------------------------------------------------
// tb_estacao_reserva_add
// Self-checking bench for one ADD-class reservation station (RS_TAG=1,
// EXEC_LATENCY=2). Expected results come from a plain opcode->arithmetic
// model and expected timing from "operands ready edge + latency + 2".
// ---------------------------------------------------------------------------
module tb_estacao_reserva_add;
    import estacao_reserva_pkg::*;

    localparam int LAT = 2;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Enable_VQ = 1'b0;
    logic [2:0]  Ufop = 3'd0;
    logic [15:0] Vj = 16'd0;
    logic [15:0] Vk = 16'd0;
    logic [2:0]  Qj = 3'd0;
    logic [2:0]  Qk = 3'd0;
    logic [3:0]  R_target = 4'd0;
    logic        Cdb_valid = 1'b0;
    logic [2:0]  Cdb_tag = 3'd0;
    logic [15:0] Cdb_data = 16'd0;
    logic        Cdb_grant = 1'b0;
    logic        Busy;
    logic        Cdb_req;
    logic [2:0]  Cdb_tag_out;
    logic [15:0] Cdb_data_out;
    logic [3:0]  R_target_out;
    logic        Dispatch_drop;

    int   checks = 0;
    int   failures = 0;
    int   edgeCount = 0;
    int   reqRiseEdge = -1;
    logic prevReq = 1'b0;

    estacao_reserva_add #(.RS_TAG(3'd1), .EXEC_LATENCY(LAT)) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Enable_VQ     (Enable_VQ),
        .Ufop          (Ufop),
        .Vj            (Vj),
        .Vk            (Vk),
        .Qj            (Qj),
        .Qk            (Qk),
        .R_target      (R_target),
        .Cdb_valid     (Cdb_valid),
        .Cdb_tag       (Cdb_tag),
        .Cdb_data      (Cdb_data),
        .Cdb_grant     (Cdb_grant),
        .Busy          (Busy),
        .Cdb_req       (Cdb_req),
        .Cdb_tag_out   (Cdb_tag_out),
        .Cdb_data_out  (Cdb_data_out),
        .R_target_out  (R_target_out),
        .Dispatch_drop (Dispatch_drop)
    );

    // Free-running clock and an edge counter used to measure latencies
    always #5 Clock = ~Clock;

    always @(posedge Clock) edgeCount++;

    // Reference ALU straight from the opcode table
    function automatic logic [15:0] aluModel(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return 16'h0000;
        endcase
    endfunction

    // Advance one edge and sample 1 time unit later; also remember the
    // edge on which Cdb_req was first seen high
    task automatic tick();
        @(posedge Clock);
        #1;
        if (Cdb_req === 1'b1 && prevReq !== 1'b1) reqRiseEdge = edgeCount;
        prevReq = Cdb_req;
    endtask

    task automatic idleBus();
        Cdb_valid = 1'b0;
        Cdb_tag   = 3'd0;
        Cdb_data  = 16'd0;
    endtask

    // Present one instruction for exactly one edge; cap is that edge
    task automatic dispatch(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] tj, input logic [2:0] tk, input logic [3:0] rt,
                            output int cap);
        Enable_VQ = 1'b1;
        Ufop = op; Vj = a; Vk = b; Qj = tj; Qk = tk; R_target = rt;
        reqRiseEdge = -1;
        tick();
        cap = edgeCount;
        Enable_VQ = 1'b0;
    endtask

    task automatic waitReq(output bit ok);
        for (int i = 0; i < 40 && Cdb_req !== 1'b1; i++) tick();
        ok = (Cdb_req === 1'b1);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        tick(); tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Cdb_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b expected 0", Cdb_req); end
        checks++; if (Cdb_tag_out !== 3'd0) begin failures++; $display("[TB] FAIL reset_tag: got %0d expected 0", Cdb_tag_out); end
        checks++; if (Cdb_data_out !== 16'hFFF0) begin failures++; $display("[TB] FAIL reset_data: got %h expected fff0", Cdb_data_out); end
        checks++; if (R_target_out !== 4'd0) begin failures++; $display("[TB] FAIL reset_rtarget: got %0d expected 0", R_target_out); end
        checks++; if (Dispatch_drop !== 1'b0) begin failures++; $display("[TB] FAIL reset_drop: got %b expected 0", Dispatch_drop); end
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ready_ops();
        int cap; bit ok;
        Cdb_grant = 1'b1;
        dispatch(OP_ADD, 16'd5, 16'd7, 3'd0, 3'd0, 4'd3, cap);
        checks++; if (Busy !== 1'b1) begin failures++; $display("[TB] FAIL ready_busy: got %b expected 1", Busy); end
        waitReq(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL ready_timeout: Cdb_req got 0 expected 1"); end
        checks++; if (reqRiseEdge - cap != 1 + LAT + 1) begin failures++; $display("[TB] FAIL ready_latency: got %0d expected %0d", reqRiseEdge - cap, 1 + LAT + 1); end
        checks++; if (Cdb_data_out !== 16'd12) begin failures++; $display("[TB] FAIL ready_data: got %0d expected 12", Cdb_data_out); end
        checks++; if (Cdb_tag_out !== 3'd1) begin failures++; $display("[TB] FAIL ready_tag: got %0d expected 1", Cdb_tag_out); end
        checks++; if (R_target_out !== 4'd3) begin failures++; $display("[TB] FAIL ready_rtarget: got %0d expected 3", R_target_out); end
        tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL ready_busy_after: got %b expected 0", Busy); end
        checks++; if (Cdb_req !== 1'b0) begin failures++; $display("[TB] FAIL ready_req_after: got %b expected 0", Cdb_req); end
        checks++; if (Cdb_tag_out !== 3'd0) begin failures++; $display("[TB] FAIL ready_tag_after: got %0d expected 0", Cdb_tag_out); end
    endtask

    task automatic test_pending();
        int cap; bit ok;
        Cdb_grant = 1'b1;
        dispatch(OP_SUB, 16'h1234, 16'd1, 3'd2, 3'd0, 4'd5, cap);
        tick();
        Cdb_valid = 1'b1; Cdb_tag = 3'd3; Cdb_data = 16'd99;
        tick();
        idleBus();
        checks++; if (Cdb_req !== 1'b0 || Busy !== 1'b1) begin failures++; $display("[TB] FAIL pending_waiting: req/busy got %b/%b expected 0/1", Cdb_req, Busy); end
        Cdb_valid = 1'b1; Cdb_tag = 3'd2; Cdb_data = 16'd10;
        tick();
        idleBus();
        waitReq(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL pending_timeout: Cdb_req got 0 expected 1"); end
        checks++; if (reqRiseEdge - cap != 3 + LAT + 2) begin failures++; $display("[TB] FAIL pending_latency: got %0d expected %0d", reqRiseEdge - cap, 3 + LAT + 2); end
        checks++; if (Cdb_data_out !== 16'd9) begin failures++; $display("[TB] FAIL pending_data: got %0d expected 9", Cdb_data_out); end
        checks++; if (R_target_out !== 4'd5) begin failures++; $display("[TB] FAIL pending_rtarget: got %0d expected 5", R_target_out); end
        tick();
    endtask

    task automatic test_forward();
        int cap; bit ok;
        Cdb_grant = 1'b1;
        Cdb_valid = 1'b1; Cdb_tag = 3'd2; Cdb_data = 16'd4;
        dispatch(OP_ADD, 16'd4, 16'hBEEF, 3'd0, 3'd2, 4'd6, cap);
        idleBus();
        waitReq(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL forward_timeout: Cdb_req got 0 expected 1"); end
        checks++; if (reqRiseEdge - cap != 1 + LAT + 1) begin failures++; $display("[TB] FAIL forward_latency: got %0d expected %0d", reqRiseEdge - cap, 1 + LAT + 1); end
        checks++; if (Cdb_data_out !== 16'd8) begin failures++; $display("[TB] FAIL forward_data: got %0d expected 8", Cdb_data_out); end
        checks++; if (R_target_out !== 4'd6) begin failures++; $display("[TB] FAIL forward_rtarget: got %0d expected 6", R_target_out); end
        tick();
    endtask

    task automatic test_wraparound();
        logic [2:0]  opTab[2]  = '{OP_ADD, OP_SUB};
        logic [15:0] aTab[2]   = '{16'hFFFF, 16'h0000};
        logic [15:0] bTab[2]   = '{16'h0001, 16'h0001};
        logic [15:0] expTab[2] = '{16'h0000, 16'hFFFF};
        int cap; bit ok;
        Cdb_grant = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dispatch(opTab[i], aTab[i], bTab[i], 3'd0, 3'd0, 4'd8, cap);
            waitReq(ok);
            checks++; if (!ok || Cdb_data_out !== expTab[i]) begin failures++; $display("[TB] FAIL wrap_%0d: got %h expected %h", i, Cdb_data_out, expTab[i]); end
            tick();
        end
    endtask

    task automatic test_grant_stall();
        int cap; bit ok;
        logic [2:0]  op;
        logic [15:0] a, b, expData;
        Cdb_grant = 1'b0;
        op = 3'($urandom_range(1, 4));
        a = 16'($urandom); b = 16'($urandom);
        expData = aluModel(op, a, b);
        dispatch(op, a, b, 3'd0, 3'd0, 4'd9, cap);
        waitReq(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL stall_timeout: Cdb_req got 0 expected 1"); end
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                Enable_VQ = 1'b1; Ufop = OP_ADD; Vj = ~a; Vk = ~b; Qj = 3'd0; Qk = 3'd0; R_target = 4'd1;
            end
            tick();
            Enable_VQ = 1'b0;
            checks++; if (Cdb_req !== 1'b1 || Cdb_tag_out !== 3'd1) begin failures++; $display("[TB] FAIL stall_req_%0d: req/tag got %b/%0d expected 1/1", i, Cdb_req, Cdb_tag_out); end
            checks++; if (Cdb_data_out !== expData || R_target_out !== 4'd9) begin failures++; $display("[TB] FAIL stall_hold_%0d: data/rt got %h/%0d expected %h/9", i, Cdb_data_out, R_target_out, expData); end
            if (i == 2) begin
                checks++; if (Dispatch_drop !== 1'b1) begin failures++; $display("[TB] FAIL stall_drop: got %b expected 1", Dispatch_drop); end
            end
            if (i == 3) begin
                checks++; if (Dispatch_drop !== 1'b0) begin failures++; $display("[TB] FAIL stall_drop_end: got %b expected 0", Dispatch_drop); end
            end
        end
        Cdb_grant = 1'b1;
        tick();
        checks++; if (Busy !== 1'b0 || Cdb_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_release: busy/req got %b/%b expected 0/0", Busy, Cdb_req); end
        Cdb_grant = 1'b0;
    endtask

    task automatic test_random();
        int cap, d2, d3, maxK, readyDelay; bit ok;
        logic [2:0]  op, tj, tk;
        logic [15:0] a, b, data2, data3, ej, ek;
        logic [2:0]  tagSel[3] = '{3'd0, 3'd2, 3'd3};
        Cdb_grant = 1'b0;
        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom_range(0, 7));
            a = 16'($urandom); b = 16'($urandom);
            data2 = 16'($urandom); data3 = 16'($urandom);
            tj = tagSel[$urandom_range(0, 2)];
            tk = tagSel[$urandom_range(0, 2)];
            d2 = $urandom_range(0, 4);
            d3 = $urandom_range(0, 4);
            if (d3 == d2) d3 = d2 + 1;
            maxK = (d2 > d3) ? d2 : d3;
            ej = (tj == 3'd0) ? a : ((tj == 3'd2) ? data2 : data3);
            ek = (tk == 3'd0) ? b : ((tk == 3'd2) ? data2 : data3);
            readyDelay = 0;
            if (tj == 3'd2 || tk == 3'd2) readyDelay = d2;
            if ((tj == 3'd3 || tk == 3'd3) && d3 > readyDelay) readyDelay = d3;
            cap = 0;
            reqRiseEdge = -1;
            for (int k = 0; k <= maxK; k++) begin
                if (k == 0) begin
                    Enable_VQ = 1'b1; Ufop = op; Vj = a; Vk = b; Qj = tj; Qk = tk; R_target = 4'(n);
                end
                if (k == d2) begin Cdb_valid = 1'b1; Cdb_tag = 3'd2; Cdb_data = data2; end
                else if (k == d3) begin Cdb_valid = 1'b1; Cdb_tag = 3'd3; Cdb_data = data3; end
                else idleBus();
                tick();
                if (k == 0) begin cap = edgeCount; Enable_VQ = 1'b0; end
            end
            idleBus();
            if (op == OP_NOP) begin
                checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL rand_nop_%0d: busy got %b expected 0", n, Busy); end
            end else begin
                waitReq(ok);
                checks++; if (!ok || reqRiseEdge - cap != readyDelay + LAT + 2) begin failures++; $display("[TB] FAIL rand_latency_%0d: got %0d expected %0d", n, reqRiseEdge - cap, readyDelay + LAT + 2); end
                checks++; if (Cdb_data_out !== aluModel(op, ej, ek)) begin failures++; $display("[TB] FAIL rand_data_%0d: got %h expected %h", n, Cdb_data_out, aluModel(op, ej, ek)); end
                checks++; if (Cdb_tag_out !== 3'd1 || R_target_out !== 4'(n)) begin failures++; $display("[TB] FAIL rand_tag_rt_%0d: got %0d/%0d expected 1/%0d", n, Cdb_tag_out, R_target_out, n % 16); end
                Cdb_grant = 1'b1;
                tick();
                Cdb_grant = 1'b0;
                checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL rand_release_%0d: busy got %b expected 0", n, Busy); end
            end
        end
    endtask

    task automatic test_reset_exec();
        int cap; bit ok;
        Cdb_grant = 1'b1;
        dispatch(OP_ADD, 16'd100, 16'd23, 3'd0, 3'd0, 4'd7, cap);
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || Cdb_req !== 1'b0) begin failures++; $display("[TB] FAIL rstexec_flags: busy/req got %b/%b expected 0/0", Busy, Cdb_req); end
        checks++; if (Cdb_data_out !== 16'hFFF0 || R_target_out !== 4'd0) begin failures++; $display("[TB] FAIL rstexec_data: data/rt got %h/%0d expected fff0/0", Cdb_data_out, R_target_out); end
        tick();
        Reset_n = 1'b1;
        tick();
        dispatch(OP_OR, 16'h0F00, 16'h00F0, 3'd0, 3'd0, 4'd2, cap);
        waitReq(ok);
        checks++; if (!ok || reqRiseEdge - cap != 1 + LAT + 1) begin failures++; $display("[TB] FAIL rstexec_latency: got %0d expected %0d", reqRiseEdge - cap, 1 + LAT + 1); end
        checks++; if (Cdb_data_out !== 16'h0FF0 || R_target_out !== 4'd2) begin failures++; $display("[TB] FAIL rstexec_result: data/rt got %h/%0d expected 0ff0/2", Cdb_data_out, R_target_out); end
        tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL rstexec_release: busy got %b expected 0", Busy); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_ready_ops();
        test_pending();
        test_forward();
        test_wraparound();
        test_grant_stall();
        test_random();
        test_reset_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
